// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared definitions for the load/store initiator: RISC-V funct3 codes,
// RAM access-type encodings, the controller state enum, and helpers that
// classify a request as illegal or word-crossing.
package lsu_pkg;

    // Load/store funct3 codes (stores reuse the low three encodings)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // RAM rwtyp encodings
    localparam logic [2:0] RW_BYTE = 3'b000;
    localparam logic [2:0] RW_HALF = 3'b001;
    localparam logic [2:0] RW_WORD = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        CAP,
        LD0,
        LD1,
        LDC,
        STB,
        RESP
    } lsu_state_t;

    // Stores only exist as SB/SH/SW; loads 011/110/111 are unused encodings
    function automatic logic isIllegal(input logic we, input logic [2:0] f3);
        if (we) begin
            return !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
        end
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // An access crosses a word when its last byte lands in the next word
    function automatic logic isCross(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && (off == 2'b11)) ||
               ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align
// Combinational load-result formatter. Shifts a two-word window right by
// the byte offset, then truncates and sign/zero-extends per funct3.
// Ports:
//   words_i  [63:0] : {upper word, lower word} read window
//   off_i    [1:0]  : byte offset of the access inside the lower word
//   funct3_i [2:0]  : load type
//   result_o [31:0] : extended load result
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] words_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted  = 32'(words_i >> {off_i, 3'b000});
        result_o = shifted;
        case (funct3_i)
            F3_B:    result_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   result_o = {24'd0, shifted[7:0]};
            F3_HU:   result_o = {16'd0, shifted[15:0]};
            default: result_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master
// Load/store initiator between the core memory stage and a byte-enabled
// data RAM. Handles one request at a time; word-crossing loads are done as
// two word reads, word-crossing stores as a sequence of byte writes.
// Ports:
//   clk, rstn                     : clock, async active-low reset
//   req_valid_i / req_ready_o     : request handshake (ready only in IDLE)
//   req_we_i, req_funct3_i        : store flag and RISC-V access type
//   req_addr_i, req_wdata_i       : byte address, right-aligned store data
//   rsp_valid_o, rsp_rdata_o      : one-cycle completion pulse and load data
//   rsp_err_o                     : illegal funct3 or rejected crossing access
//   mem_rwtyp_o, mem_addr_o       : RAM access type and byte address
//   mem_data_o, mem_wren_o        : RAM write data and write enable
//   mem_rden_o, mem_q_i           : RAM read enable and next-cycle read data
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [2:0]            mem_rwtyp_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_data_o,
    output logic                  mem_wren_o,
    output logic                  mem_rden_o,
    input  logic [31:0]           mem_q_i
);

    lsu_state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word0_q, word0_d;

    logic                  reqReady_q, reqReady_d;
    logic                  rspValid_q, rspValid_d;
    logic [31:0]           rspRdata_q, rspRdata_d;
    logic                  rspErr_q, rspErr_d;
    logic [2:0]            memRwtyp_q, memRwtyp_d;
    logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
    logic [31:0]           memData_q, memData_d;
    logic                  memWren_q, memWren_d;
    logic                  memRden_q, memRden_d;

    logic [63:0] alignWords;
    logic [1:0]  alignOff;
    logic [31:0] alignResult;
    logic [1:0]  lastIdx;
    logic [7:0]  stbByte;
    logic [ADDR_WIDTH-1:0] wordBase;

    // Single formatter shared by the aligned capture and the crossing combine
    lsu_load_align u_align (
        .words_i  (alignWords),
        .off_i    (alignOff),
        .funct3_i (funct3_q),
        .result_o (alignResult)
    );

    // Next-state logic. The RAM already lane-shifts aligned reads, so CAP
    // feeds the formatter with offset 0; LDC feeds both captured words.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        funct3_d   = funct3_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        word0_d    = word0_q;
        rspErr_d   = 1'b0;
        rspRdata_d = 32'd0;
        alignWords = {32'd0, mem_q_i};
        alignOff   = 2'b00;
        lastIdx    = (funct3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
        case (state_q)
            IDLE: begin
                if (req_valid_i && reqReady_q) begin
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    funct3_d = req_funct3_i;
                    we_d     = req_we_i;
                    cnt_d    = 2'd0;
                    if (isIllegal(req_we_i, req_funct3_i) ||
                        (isCross(req_funct3_i, req_addr_i[1:0]) && !MISALIGN_EN)) begin
                        state_d  = RESP;
                        rspErr_d = 1'b1;
                    end else if (isCross(req_funct3_i, req_addr_i[1:0])) begin
                        state_d = req_we_i ? STB : LD0;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: state_d = we_q ? RESP : CAP;
            CAP: begin
                rspRdata_d = alignResult;
                state_d    = RESP;
            end
            LD0: state_d = LD1;
            LD1: begin
                word0_d = mem_q_i;
                state_d = LDC;
            end
            LDC: begin
                alignWords = {mem_q_i, word0_q};
                alignOff   = addr_q[1:0];
                rspRdata_d = alignResult;
                state_d    = RESP;
            end
            STB: begin
                if (cnt_q == lastIdx) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output registers are loaded with the values for the state being
    // entered, so every output is a flop yet lines up with its state.
    always_comb begin
        memRwtyp_d = memRwtyp_q;
        memAddr_d  = memAddr_q;
        memData_d  = memData_q;
        memWren_d  = 1'b0;
        memRden_d  = 1'b0;
        wordBase   = {addr_d[ADDR_WIDTH-1:2], 2'b00};
        stbByte    = 8'(wdata_d >> {cnt_d, 3'b000});
        case (state_d)
            ACC: begin
                memRwtyp_d = funct3_d;
                memAddr_d  = addr_d;
                memData_d  = wdata_d;
                memWren_d  = we_d;
                memRden_d  = !we_d;
            end
            LD0: begin
                memRwtyp_d = RW_WORD;
                memAddr_d  = wordBase;
                memRden_d  = 1'b1;
            end
            LD1: begin
                memRwtyp_d = RW_WORD;
                memAddr_d  = wordBase + ADDR_WIDTH'(4);
                memRden_d  = 1'b1;
            end
            STB: begin
                memRwtyp_d = RW_BYTE;
                memAddr_d  = addr_d + ADDR_WIDTH'(cnt_d);
                memData_d  = {24'd0, stbByte};
                memWren_d  = 1'b1;
            end
            default: ;
        endcase
        rspValid_d = (state_d == RESP);
        reqReady_d = (state_d == IDLE);
    end

    // State, request latches and output flops; reset drops any operation
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            funct3_q   <= '0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            word0_q    <= '0;
            reqReady_q <= 1'b0;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b0;
            memRwtyp_q <= '0;
            memAddr_q  <= '0;
            memData_q  <= '0;
            memWren_q  <= 1'b0;
            memRden_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            funct3_q   <= funct3_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            word0_q    <= word0_d;
            reqReady_q <= reqReady_d;
            rspValid_q <= rspValid_d;
            rspRdata_q <= rspRdata_d;
            rspErr_q   <= rspErr_d;
            memRwtyp_q <= memRwtyp_d;
            memAddr_q  <= memAddr_d;
            memData_q  <= memData_d;
            memWren_q  <= memWren_d;
            memRden_q  <= memRden_d;
        end
    end

    assign req_ready_o = reqReady_q;
    assign rsp_valid_o = rspValid_q;
    assign rsp_rdata_o = rspRdata_q;
    assign rsp_err_o   = rspErr_q;
    assign mem_rwtyp_o = memRwtyp_q;
    assign mem_addr_o  = memAddr_q;
    assign mem_data_o  = memData_q;
    assign mem_wren_o  = memWren_q;
    assign mem_rden_o  = memRden_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master
// Directed bench for lsu_mem_master. Instance A (splitting enabled) talks to
// a byte-addressed RAM model; instance B (splitting disabled) sees only
// requests that must be rejected. Expected responses are queued when a
// request is issued and popped by per-instance response monitors.
module tb_lsu_mem_master;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cycle;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    int   cycle = 0;
    int   errors = 0;
    int   checks = 0;

    // Instance A signals
    logic        reqValidA, reqWeA, reqReadyA, rspValidA, rspErrA;
    logic [2:0]  reqFunct3A, memRwtypA;
    logic [31:0] reqAddrA, reqWdataA, rspRdataA, memAddrA, memDataA, memQA;
    logic        memWrenA, memRdenA;
    // Instance B signals
    logic        reqValidB, reqWeB, reqReadyB, rspValidB, rspErrB;
    logic [2:0]  reqFunct3B, memRwtypB;
    logic [31:0] reqAddrB, reqWdataB, rspRdataB, memAddrB, memDataB;
    logic [31:0] memQB = 32'd0;
    logic        memWrenB, memRdenB;

    exp_t expA[$];
    exp_t expB[$];
    exp_t curA, curB;
    logic [63:0] wrLog[$];
    int overlapA = 0;
    int activityB = 0;

    logic [7:0]  ram [logic [31:0]];
    logic [31:0] ramRd;
    int          ramN;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    lsu_mem_master #(.ADDR_WIDTH(32), .MISALIGN_EN(1'b1)) dutA (
        .clk(clk), .rstn(rstn),
        .req_valid_i(reqValidA), .req_ready_o(reqReadyA), .req_we_i(reqWeA),
        .req_funct3_i(reqFunct3A), .req_addr_i(reqAddrA), .req_wdata_i(reqWdataA),
        .rsp_valid_o(rspValidA), .rsp_rdata_o(rspRdataA), .rsp_err_o(rspErrA),
        .mem_rwtyp_o(memRwtypA), .mem_addr_o(memAddrA), .mem_data_o(memDataA),
        .mem_wren_o(memWrenA), .mem_rden_o(memRdenA), .mem_q_i(memQA)
    );

    lsu_mem_master #(.ADDR_WIDTH(32), .MISALIGN_EN(1'b0)) dutB (
        .clk(clk), .rstn(rstn),
        .req_valid_i(reqValidB), .req_ready_o(reqReadyB), .req_we_i(reqWeB),
        .req_funct3_i(reqFunct3B), .req_addr_i(reqAddrB), .req_wdata_i(reqWdataB),
        .rsp_valid_o(rspValidB), .rsp_rdata_o(rspRdataB), .rsp_err_o(rspErrB),
        .mem_rwtyp_o(memRwtypB), .mem_addr_o(memAddrB), .mem_data_o(memDataB),
        .mem_wren_o(memWrenB), .mem_rden_o(memRdenB), .mem_q_i(memQB)
    );

    // Byte RAM model: right-aligned data, zero-extended one-cycle reads
    always @(posedge clk) begin
        ramN = (memRwtypA[1:0] == 2'b00) ? 1 : (memRwtypA[1:0] == 2'b01) ? 2 : 4;
        if (memWrenA) begin
            for (int b = 0; b < ramN; b++) ram[memAddrA + 32'(b)] = memDataA[8*b +: 8];
        end
        if (memRdenA) begin
            ramRd = 32'd0;
            for (int b = 0; b < ramN; b++) begin
                if (ram.exists(memAddrA + 32'(b))) ramRd[8*b +: 8] = ram[memAddrA + 32'(b)];
            end
            memQA <= ramRd;
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Response monitors and RAM-port activity watchers
    always @(negedge clk) begin
        if (rspValidA) begin
            if (expA.size() == 0) begin
                checkOutput("unexpectedRspA", 1, 0);
            end else begin
                curA = expA.pop_front();
                checkOutput({curA.name, ".rdata"}, rspRdataA, curA.rdata);
                checkOutput({curA.name, ".err"}, rspErrA, curA.err);
                checkOutput({curA.name, ".cycle"}, cycle, curA.cycle);
            end
        end
        if (rspValidB) begin
            if (expB.size() == 0) begin
                checkOutput("unexpectedRspB", 1, 0);
            end else begin
                curB = expB.pop_front();
                checkOutput({curB.name, ".rdata"}, rspRdataB, curB.rdata);
                checkOutput({curB.name, ".err"}, rspErrB, curB.err);
                checkOutput({curB.name, ".cycle"}, cycle, curB.cycle);
            end
        end
        if (memRdenA && memWrenA) overlapA++;
        if (memRdenB || memWrenB) activityB++;
        if (memWrenA) wrLog.push_back({memAddrA, memDataA});
    end

    task automatic applyStimulus(input bit sel, input string name, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input logic err, input int lat);
        exp_t e;
        int guard;
        guard = 0;
        @(negedge clk);
        while (!(sel ? reqReadyB : reqReadyA) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checkOutput({name, ".readyTimeout"}, 0, 1);
            return;
        end
        e.rdata = rdata;
        e.err   = err;
        e.cycle = cycle + lat;
        e.name  = name;
        if (sel) begin
            reqValidB = 1'b1; reqWeB = we; reqFunct3B = f3; reqAddrB = addr; reqWdataB = wdata;
            expB.push_back(e);
        end else begin
            reqValidA = 1'b1; reqWeA = we; reqFunct3A = f3; reqAddrA = addr; reqWdataA = wdata;
            expA.push_back(e);
        end
        @(negedge clk);
        reqValidA = 1'b0;
        reqValidB = 1'b0;
        checkOutput({name, ".readyLow"}, sel ? reqReadyB : reqReadyA, 0);
        guard = 0;
        while ((expA.size() + expB.size()) != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            checkOutput({name, ".rspTimeout"}, 0, 1);
            expA.delete();
            expB.delete();
        end
    endtask

    task automatic checkWrites(input string name, input logic [63:0] want[], input int n);
        checkOutput({name, ".count"}, wrLog.size(), n);
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s.wr%0d", name, i), (i < wrLog.size()) ? wrLog[i] : '1, want[i]);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [63:0] swWant[];
        logic [63:0] shWant[];
        swWant = '{{32'h201, 32'h44}, {32'h202, 32'h33}, {32'h203, 32'h22}, {32'h204, 32'h11}};
        shWant = '{{32'hFFFFFFFF, 32'hCD}, {32'h00000000, 32'hAB}};
        reqValidA = 0; reqWeA = 0; reqFunct3A = 0; reqAddrA = 0; reqWdataA = 0;
        reqValidB = 0; reqWeB = 0; reqFunct3B = 0; reqAddrB = 0; reqWdataB = 0;
        memQA = 0;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetOutsA", {reqReadyA, rspValidA, rspRdataA, rspErrA, memRwtypA,
                                   memAddrA, memDataA, memWrenA, memRdenA}, 0);
        rstn = 1'b1;
        @(posedge clk);
        #1 checkOutput("readyAfterReset", reqReadyA, 1);

        // Aligned word store/load
        applyStimulus(0, "swAligned", 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 2);
        applyStimulus(0, "lwAligned", 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 3);
        // Byte stores and sign/zero extension
        applyStimulus(0, "sb102", 1, 3'b000, 32'h102, 32'h00, 0, 0, 2);
        applyStimulus(0, "sb103", 1, 3'b000, 32'h103, 32'h80, 0, 0, 2);
        applyStimulus(0, "lb103", 0, 3'b000, 32'h103, 0, 32'hFFFFFF80, 0, 3);
        applyStimulus(0, "lbu103", 0, 3'b100, 32'h103, 0, 32'h00000080, 0, 3);
        applyStimulus(0, "lhu102", 0, 3'b101, 32'h102, 0, 32'h00008000, 0, 3);
        // Crossing word store splits into four byte writes
        wrLog.delete();
        applyStimulus(0, "swCross", 1, 3'b010, 32'h201, 32'h11223344, 0, 0, 5);
        checkWrites("swCrossWr", swWant, 4);
        applyStimulus(0, "lwCross", 0, 3'b010, 32'h201, 0, 32'h11223344, 0, 4);
        // Crossing halfword loads and an aligned offset-2 halfword
        applyStimulus(0, "sb203", 1, 3'b000, 32'h203, 32'h80, 0, 0, 2);
        applyStimulus(0, "sb204", 1, 3'b000, 32'h204, 32'hFF, 0, 0, 2);
        applyStimulus(0, "lhCross", 0, 3'b001, 32'h203, 0, 32'hFFFFFF80, 0, 4);
        applyStimulus(0, "lhuCross", 0, 3'b101, 32'h203, 0, 32'h0000FF80, 0, 4);
        applyStimulus(0, "lh202", 0, 3'b001, 32'h202, 0, 32'hFFFF8033, 0, 3);
        // Crossing halfword store wrapping past the top of the address space
        wrLog.delete();
        applyStimulus(0, "shWrap", 1, 3'b001, 32'hFFFFFFFF, 32'h0000ABCD, 0, 0, 3);
        checkWrites("shWrapWr", shWant, 2);
        applyStimulus(0, "lbu0", 0, 3'b100, 32'h0, 0, 32'h000000AB, 0, 3);
        applyStimulus(0, "lbTop", 0, 3'b000, 32'hFFFFFFFF, 0, 32'hFFFFFFCD, 0, 3);
        // Illegal funct3 encodings
        applyStimulus(0, "stIllegal", 1, 3'b011, 32'h100, 32'h1, 0, 1, 1);
        applyStimulus(0, "ldIllegal", 0, 3'b110, 32'h100, 0, 0, 1, 1);
        // Splitting disabled: crossing and illegal requests are rejected
        applyStimulus(1, "noMisLw", 0, 3'b010, 32'h202, 0, 0, 1, 1);
        applyStimulus(1, "noMisF3", 0, 3'b011, 32'h300, 0, 0, 1, 1);
        applyStimulus(1, "noMisSh", 1, 3'b001, 32'h203, 32'h1234, 0, 1, 1);

        // Reset in the middle of a crossing load (during LD1)
        @(negedge clk);
        reqValidA = 1'b1; reqWeA = 1'b0; reqFunct3A = 3'b010; reqAddrA = 32'h201;
        @(posedge clk);
        @(negedge clk);
        reqValidA = 1'b0;
        @(posedge clk);
        #2 rstn = 1'b0;
        #1 checkOutput("midResetOutsA", {reqReadyA, rspValidA, rspRdataA, rspErrA, memRwtypA,
                                         memAddrA, memDataA, memWrenA, memRdenA}, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1 checkOutput("readyAfterMidReset", reqReadyA, 1);
        repeat (6) @(negedge clk);
        applyStimulus(0, "lwAfterReset", 0, 3'b010, 32'h201, 0, 32'hFF803344, 0, 4);

        checkOutput("rdenWrenOverlapA", overlapA, 0);
        checkOutput("memActivityB", activityB, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
